// File: rtl/fifo_access_arbiter_pkg.sv
// rtl/fifo_access_arbiter_pkg.sv - shared constants and helpers for the FIFO access arbiter
package fifo_arb_pkg;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ST_RUN   = 1'b0;
    localparam arb_state_t ST_FLUSH = 1'b1;

    localparam int DW_DEFAULT = 8;
    localparam int STAT_W     = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_access_arbiter_if.sv
// rtl/fifo_access_arbiter_if.sv - producer, consumer and FIFO control bundle of the arbiter
interface fifo_access_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT
);
    logic [1:0]    wr_valid;
    logic [DW-1:0] wr_data0;
    logic [DW-1:0] wr_data1;
    logic [1:0]    wr_ready;
    logic          rd_req;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          flush;
    logic          flush_done;
    logic          fifo_en;
    logic          fifo_wr;
    logic          fifo_rd;
    logic [DW-1:0] fifo_din;
    logic [DW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;

    // master: the arbiter itself; slave: producers, consumer and the FIFO around it
    modport master (
        input  wr_valid, wr_data0, wr_data1, rd_req, flush,
               fifo_dout, fifo_full, fifo_empty,
        output wr_ready, rd_valid, rd_data, flush_done,
               fifo_en, fifo_wr, fifo_rd, fifo_din
    );

    modport slave (
        output wr_valid, wr_data0, wr_data1, rd_req, flush,
               fifo_dout, fifo_full, fifo_empty,
        input  wr_ready, rd_valid, rd_data, flush_done,
               fifo_en, fifo_wr, fifo_rd, fifo_din
    );

endinterface

// File: rtl/fifo_access_arbiter_rr_arb2.sv
// rtl/fifo_access_arbiter_rr_arb2.sv - two-input round-robin grant with last-grant memory
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_idx
);
    logic last_grant;

    always_comb begin
        grant_idx = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
        grant = (req == 2'b00) ? 2'b00 : (grant_idx ? 2'b10 : 2'b01);
    end

    // Reset to producer 1 so producer 0 wins the first contested cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (advance && (|req)) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/fifo_access_arbiter.sv
// rtl/fifo_access_arbiter.sv - round-robin write sharing, read sequencing and flush for a 16x8 FIFO
// Optional per-producer transfer counters are built when ARB_STATS_EN is defined.
module fifo_access_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_access_arbiter_if.master bus
`ifdef ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]     grant_cnt0,
    output logic [STAT_W-1:0]     grant_cnt1
`endif
);
    arb_state_t      state;
    logic            en_q;
    logic            rd_valid_q;
    logic            flush_done_q;
    logic            run;
    logic            can_wr;
    logic            grant_idx;
    logic [NREQ-1:0] grant;
    logic [DW-1:0]   din_mux;

    assign run    = (state == ST_RUN);
    assign can_wr = !rst && run && en_q && !bus.fifo_full;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.wr_valid),
        .advance   (can_wr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign din_mux        = grant_idx ? bus.wr_data1 : bus.wr_data0;
    assign bus.wr_ready   = can_wr ? grant : '0;
    assign bus.fifo_wr    = can_wr && (|grant);
    assign bus.fifo_din   = rst ? '0 : din_mux;
    assign bus.fifo_rd    = !rst && (run ? (bus.rd_req && !bus.fifo_empty && en_q)
                                         : !bus.fifo_empty);
    assign bus.rd_data    = rst ? '0 : bus.fifo_dout;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.flush_done = flush_done_q;
    assign bus.fifo_en    = en_q;

    // A read issued on the flush cycle is discarded along with the rest of the drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            en_q         <= 1'b0;
            rd_valid_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            en_q         <= 1'b1;
            rd_valid_q   <= run && bus.fifo_rd && !bus.flush;
            flush_done_q <= 1'b0;
            if (run) begin
                if (bus.flush) begin
                    state <= ST_FLUSH;
                end
            end else if (bus.fifo_empty) begin
                state        <= ST_RUN;
                flush_done_q <= 1'b1;
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (bus.wr_ready[0]) begin
                grant_cnt0 <= sat_inc(grant_cnt0);
            end
            if (bus.wr_ready[1]) begin
                grant_cnt1 <= sat_inc(grant_cnt1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb/tb_fifo_access_arbiter.sv - scoreboard bench for fifo_access_arbiter with a 16-deep FIFO model
module tb_fifo_access_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_access_arbiter_if #(.DW(8)) bus ();

`ifdef ARB_STATS_EN
    logic [7:0] gc0;
    logic [7:0] gc1;
`endif

    fifo_access_arbiter #(.DW(8), .NREQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt0 (gc0),
        .grant_cnt1 (gc1)
`endif
    );

    // Stand-in for the FIFO16_8bit instance: registered read data, enable-gated.
    logic [7:0] mem [16];
    logic [3:0] wp, rp;
    logic [4:0] cnt;
    logic [7:0] f_dout;
    logic       wr_ok, rd_ok;

    assign bus.fifo_full  = (cnt == 5'd16);
    assign bus.fifo_empty = (cnt == 5'd0);
    assign bus.fifo_dout  = f_dout;

    always @(posedge clk) begin
        if (rst) begin
            wp <= '0; rp <= '0; cnt <= '0; f_dout <= '0;
        end else if (bus.fifo_en) begin
            wr_ok = bus.fifo_wr && (cnt != 5'd16);
            rd_ok = bus.fifo_rd && (cnt != 5'd0);
            if (rd_ok) begin
                f_dout <= mem[rp];
                rp     <= rp + 4'd1;
            end
            if (wr_ok) begin
                mem[wp] <= bus.fifo_din;
                wp      <= wp + 4'd1;
            end
            cnt <= cnt + 5'(wr_ok) - 5'(rd_ok);
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, pending read results as a scoreboard queue.
    logic [7:0] ref_q [$];
    logic [7:0] pend_q [$];
    int  m_last = 1;
    bit  m_flush = 0, m_en = 0, m_rdv = 0, m_done = 0;
    int  m_cnt [2] = '{0, 0};
    bit  mon_on = 0;

    always @(negedge clk) begin
        logic [1:0] e_ready;
        logic       e_rd, e_wr, full, empty;
        logic [7:0] e_din, b;
        int         g;
        if (mon_on) begin
            chk("rd_valid", bus.rd_valid, m_rdv);
            chk("flush_done", bus.flush_done, m_done);
            chk("fifo_en", bus.fifo_en, m_en);
`ifdef ARB_STATS_EN
            chk("grant_cnt0", gc0, m_cnt[0]);
            chk("grant_cnt1", gc1, m_cnt[1]);
`endif
            if (bus.rd_valid === 1'b1) begin
                checks++;
                if (pend_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_valid_unexpected actual=1 expected=0 at %0t", $time);
                end else begin
                    b = pend_q.pop_front();
                    checks--;
                    chk("rd_data", bus.rd_data, b);
                end
            end
            if (rst) begin
                chk("wr_ready_rst", bus.wr_ready, 0);
                chk("fifo_wr_rst", bus.fifo_wr, 0);
                chk("fifo_rd_rst", bus.fifo_rd, 0);
                ref_q.delete(); pend_q.delete();
                m_last = 1; m_flush = 0; m_en = 0; m_rdv = 0; m_done = 0;
                m_cnt[0] = 0; m_cnt[1] = 0;
            end else begin
                full  = (ref_q.size() >= 16);
                empty = (ref_q.size() == 0);
                e_ready = 2'b00;
                e_rd = 1'b0;
                g = 0;
                if (!m_flush) begin
                    if (bus.wr_valid == 2'b11) g = (m_last == 1) ? 0 : 1;
                    else g = int'(bus.wr_valid[1]);
                    if (m_en && !full && bus.wr_valid != 2'b00) e_ready[g] = 1'b1;
                    e_rd = bus.rd_req && !empty && m_en;
                end else begin
                    e_rd = !empty;
                end
                e_wr  = |e_ready;
                e_din = (g == 1) ? bus.wr_data1 : bus.wr_data0;
                chk("wr_ready", bus.wr_ready, e_ready);
                chk("fifo_wr", bus.fifo_wr, e_wr);
                chk("fifo_rd", bus.fifo_rd, e_rd);
                if (e_wr) chk("fifo_din", bus.fifo_din, e_din);
                if (e_rd) begin
                    b = ref_q.pop_front();
                    if (!m_flush && !bus.flush) pend_q.push_back(b);
                end
                if (e_wr) begin
                    ref_q.push_back(e_din);
                    m_last = g;
                end
                if (bus.flush) begin
                    m_cnt[0] = 0; m_cnt[1] = 0;
                end else if (e_wr && m_cnt[g] < 255) begin
                    m_cnt[g]++;
                end
                m_rdv   = e_rd && !m_flush && !bus.flush;
                m_done  = m_flush && empty;
                m_flush = m_flush ? !empty : bus.flush;
                m_en    = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_valid = 2'b00;
        bus.rd_req   = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic write0(input int n);
        bus.wr_valid = 2'b01;
        repeat (n) begin
            bus.wr_data0 = 8'($urandom);
            step();
        end
        idle();
    endtask

    task automatic drain(input int n);
        bus.rd_req = 1'b1;
        repeat (n) step();
        idle();
    endtask

    task automatic flush_and_wait(input string nm);
        bit seen = 0;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            bus.wr_valid = 2'($urandom);
            bus.wr_data0 = 8'($urandom);
            bus.wr_data1 = 8'($urandom);
            bus.rd_req   = 1'($urandom);
            if (bus.flush_done === 1'b1) seen = 1;
            else step();
        end
        idle();
        chk(nm, seen, 1);
    endtask

    initial begin
        idle();
        bus.wr_data0 = 8'h00;
        bus.wr_data1 = 8'h00;
        rst = 1'b1;
        step();
        mon_on = 1;
        step();
        rst = 1'b0;
        step();

        // contested writes alternate 0x11,0x22,... starting with producer 0
        bus.wr_valid = 2'b11;
        bus.wr_data0 = 8'h11;
        bus.wr_data1 = 8'h22;
        repeat (4) step();
        idle();
`ifdef ARB_STATS_EN
        chk("t1_grant_cnt0", gc0, 2);
        chk("t1_grant_cnt1", gc1, 2);
`endif
        // fill to full and keep requesting, then free one slot
        write0(16);
        chk("t2_full", bus.fifo_full, 1);
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        write0(2);
        drain(20);
        chk("t3_empty", bus.fifo_empty, 1);

        // 0x01..0x04 then five reads; the fifth finds the FIFO empty
        bus.wr_valid = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            bus.wr_data0 = 8'(i);
            step();
        end
        idle();
        drain(5);
        step();

        // concurrent write and read with two entries stored
        write0(2);
        bus.wr_valid = 2'b01;
        bus.wr_data0 = 8'h05;
        bus.rd_req   = 1'b1;
        step();
        idle();
        drain(6);

        // six entries flushed
        write0(6);
        step();
        flush_and_wait("t5_flush_done");
        step();
        flush_and_wait("flush_when_empty");

        // reset in the middle of a drain
        write0(6);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();

        for (int i = 0; i < 3000; i++) begin
            bit fl;
            fl = ($urandom_range(0, 49) == 0);
            bus.flush    = fl;
            bus.wr_valid = 2'($urandom);
            bus.wr_data0 = 8'($urandom);
            bus.wr_data1 = 8'($urandom);
            bus.rd_req   = fl ? 1'b0 : (($urandom_range(0, 9) < ((i / 300) % 2 == 0 ? 3 : 7)) ? 1'b1 : 1'b0);
            step();
        end
        idle();
        repeat (40) step();
        drain(20);
        repeat (3) step();
        mon_on = 0;
        chk("pending_reads_left", pend_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
